// File: rtl/painterengine_gpu_reader_arbiter.sv
// Two-port arbiter that shares one GPU DMA reader between the display streamer (port 0)
// and a secondary requester (port 1). Port 0 has fixed priority, bounded by a starvation limit.
module painterengine_gpu_reader_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_wire_clock,
  input  logic        i_wire_reset,
  input  logic [31:0] i_wire_r0_address,
  input  logic [31:0] i_wire_r0_length,
  input  logic        i_wire_r0_resetn,
  output logic        o_wire_r0_done,
  output logic        o_wire_r0_error,
  output logic [31:0] o_wire_r0_data,
  output logic        o_wire_r0_data_valid,
  input  logic        i_wire_r0_data_next,
  input  logic [31:0] i_wire_r1_address,
  input  logic [31:0] i_wire_r1_length,
  input  logic        i_wire_r1_resetn,
  output logic        o_wire_r1_done,
  output logic        o_wire_r1_error,
  output logic [31:0] o_wire_r1_data,
  output logic        o_wire_r1_data_valid,
  input  logic        i_wire_r1_data_next,
  output logic [31:0] o_wire_reader_address,
  output logic [31:0] o_wire_reader_length,
  output logic        o_wire_reader_resetn,
  input  logic        i_wire_reader_done,
  input  logic        i_wire_reader_error,
  input  logic        i_wire_reader_data_valid,
  input  logic [31:0] i_wire_reader_data,
  output logic        o_wire_reader_data_next,
  output logic [31:0] o_wire_state
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LIMIT   = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GRANT0  = 2'b01,
    ST_GRANT1  = 2'b10,
    ST_RELEASE = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] len_q, len_d;
  logic          rstn_q, rstn_d;
  logic [1:0]    grant;

  // Grant is a pure decode of the registered state, so it is glitch-free.
  assign grant = {state_q == ST_GRANT1, state_q == ST_GRANT0};

  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      rstn_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      rstn_q   <= rstn_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    len_d    = len_q;
    rstn_d   = rstn_q;
    unique case (state_q)
      ST_IDLE: begin
        // Port 1 wins when alone or when port 0 has starved it long enough.
        if (i_wire_r1_resetn && (!i_wire_r0_resetn || starve_q >= LIMIT)) begin
          state_d  = ST_GRANT1;
          starve_d = '0;
          addr_d   = i_wire_r1_address;
          len_d    = i_wire_r1_length;
          rstn_d   = 1'b1;
        end else if (i_wire_r0_resetn) begin
          state_d = ST_GRANT0;
          if (i_wire_r1_resetn && starve_q != CNT_MAX) begin
            starve_d = starve_q + CW'(1);
          end
          addr_d = i_wire_r0_address;
          len_d  = i_wire_r0_length;
          rstn_d = 1'b1;
        end
      end
      ST_GRANT0: begin
        if (!i_wire_r0_resetn) begin
          state_d = ST_RELEASE;
          rstn_d  = 1'b0;
        end
      end
      ST_GRANT1: begin
        if (!i_wire_r1_resetn) begin
          state_d = ST_RELEASE;
          rstn_d  = 1'b0;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
        rstn_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        rstn_d  = 1'b0;
      end
    endcase
  end

  assign o_wire_reader_address = addr_q;
  assign o_wire_reader_length  = len_q;
  assign o_wire_reader_resetn  = rstn_q;

  // Return path: status is steered to the granted port only; data fans out to both.
  assign o_wire_r0_done       = i_wire_reader_done & grant[0];
  assign o_wire_r0_error      = i_wire_reader_error & grant[0];
  assign o_wire_r0_data_valid = i_wire_reader_data_valid & grant[0];
  assign o_wire_r0_data       = i_wire_reader_data;
  assign o_wire_r1_done       = i_wire_reader_done & grant[1];
  assign o_wire_r1_error      = i_wire_reader_error & grant[1];
  assign o_wire_r1_data_valid = i_wire_reader_data_valid & grant[1];
  assign o_wire_r1_data       = i_wire_reader_data;

  assign o_wire_reader_data_next = (grant[0] & i_wire_r0_data_next) |
                                   (grant[1] & i_wire_r1_data_next);

  assign o_wire_state = {22'd0, starve_q, grant, state_q, 2'd0};

endmodule

// File: tb/tb_painterengine_gpu_reader_arbiter.sv
// Randomized and directed bench for painterengine_gpu_reader_arbiter with an owner-based reference model.
module tb_painterengine_gpu_reader_arbiter;

  localparam int unsigned STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] r_addr [2];
  logic [31:0] r_len  [2];
  logic        r_rstn [2];
  logic        r_next [2];
  logic        rd_done = 1'b0, rd_error = 1'b0, rd_valid = 1'b0;
  logic [31:0] rd_data = '0;

  logic        r0_done, r0_error, r0_valid, r1_done, r1_error, r1_valid;
  logic [31:0] r0_data, r1_data;
  logic [31:0] rd_address, rd_length, state_word;
  logic        rd_resetn, rd_next;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  painterengine_gpu_reader_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .i_wire_clock            (clk),
    .i_wire_reset            (rst),
    .i_wire_r0_address       (r_addr[0]),
    .i_wire_r0_length        (r_len[0]),
    .i_wire_r0_resetn        (r_rstn[0]),
    .o_wire_r0_done          (r0_done),
    .o_wire_r0_error         (r0_error),
    .o_wire_r0_data          (r0_data),
    .o_wire_r0_data_valid    (r0_valid),
    .i_wire_r0_data_next     (r_next[0]),
    .i_wire_r1_address       (r_addr[1]),
    .i_wire_r1_length        (r_len[1]),
    .i_wire_r1_resetn        (r_rstn[1]),
    .o_wire_r1_done          (r1_done),
    .o_wire_r1_error         (r1_error),
    .o_wire_r1_data          (r1_data),
    .o_wire_r1_data_valid    (r1_valid),
    .i_wire_r1_data_next     (r_next[1]),
    .o_wire_reader_address   (rd_address),
    .o_wire_reader_length    (rd_length),
    .o_wire_reader_resetn    (rd_resetn),
    .i_wire_reader_done      (rd_done),
    .i_wire_reader_error     (rd_error),
    .i_wire_reader_data_valid(rd_valid),
    .i_wire_reader_data      (rd_data),
    .o_wire_reader_data_next (rd_next),
    .o_wire_state            (state_word)
  );

  // Reference model: who owns the reader (-1 = nobody), whether we are in the one-cycle
  // release gap, and how many times port 1 has been passed over.
  int          m_owner = -1;
  bit          m_gap = 1'b0;
  int          m_starve = 0;
  logic [31:0] m_addr = '0, m_len = '0;
  logic        m_rstn = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_owner <= -1; m_gap <= 1'b0; m_starve <= 0;
      m_addr <= '0; m_len <= '0; m_rstn <= 1'b0;
    end else if (m_gap) begin
      m_gap <= 1'b0;
    end else if (m_owner < 0) begin
      int pick;
      pick = -1;
      if (r_rstn[1] && (!r_rstn[0] || m_starve >= int'(STARVE_LIMIT))) pick = 1;
      else if (r_rstn[0]) pick = 0;
      if (pick >= 0) begin
        m_owner <= pick;
        m_addr  <= r_addr[pick];
        m_len   <= r_len[pick];
        m_rstn  <= 1'b1;
        if (pick == 1) m_starve <= 0;
        else if (r_rstn[1]) m_starve <= (m_starve >= 15) ? 15 : m_starve + 1;
      end
    end else if (!r_rstn[m_owner]) begin
      m_owner <= -1; m_gap <= 1'b1; m_rstn <= 1'b0;
    end
  end

  function automatic logic [31:0] model_word();
    logic [1:0] g, st;
    g  = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    st = m_gap ? 2'b11 : g;
    return {22'd0, 4'(m_starve), g, st, 2'd0};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      r_addr[p] = '0; r_len[p] = '0; r_rstn[p] = 1'b0; r_next[p] = 1'b0;
    end
    rd_done = 1'b0; rd_error = 1'b0; rd_valid = 1'b0; rd_data = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (state_word !== 32'd0) begin
      errors++; $display("FAIL reset_state: got %h want 00000000", state_word);
    end
    checks++;
    if ({rd_resetn, rd_address, rd_length, rd_next} !== 66'd0) begin
      errors++; $display("FAIL reset_reader: rstn=%b addr=%h len=%h next=%b want zeros",
                         rd_resetn, rd_address, rd_length, rd_next);
    end
    checks++;
    if ({r0_done, r0_error, r0_valid, r1_done, r1_error, r1_valid} !== 6'd0) begin
      errors++; $display("FAIL reset_gated: got %b want 000000",
                         {r0_done, r0_error, r0_valid, r1_done, r1_error, r1_valid});
    end
  endtask

  task automatic test_port0_only();
    int n0, n1;
    do_reset();
    r_addr[0] = 32'h1000_0000; r_len[0] = 32'd32; r_rstn[0] = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (rd_resetn !== 1'b1 || rd_address !== 32'h1000_0000 || rd_length !== 32'd32) begin
      errors++; $display("FAIL p0_grant: rstn=%b addr=%h len=%0d want 1 10000000 32",
                         rd_resetn, rd_address, rd_length);
    end
    n0 = 0; n1 = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rd_valid = 1'b1; rd_data = $urandom; #1;
      n0 += int'(r0_valid); n1 += int'(r1_valid);
      checks++;
      if (r0_data !== rd_data || r1_data !== rd_data) begin
        errors++; $display("FAIL p0_data: r0=%h r1=%h want %h", r0_data, r1_data, rd_data);
      end
    end
    @(negedge clk);
    rd_valid = 1'b0; rd_done = 1'b1; #1;
    checks++;
    if (n0 !== 32 || n1 !== 0 || r0_done !== 1'b1 || r1_done !== 1'b0) begin
      errors++; $display("FAIL p0_counts: r0_valid=%0d r1_valid=%0d r0_done=%b r1_done=%b want 32 0 1 0",
                         n0, n1, r0_done, r1_done);
    end
    @(negedge clk);
    rd_done = 1'b0; r_rstn[0] = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (state_word[3:2] !== 2'b11 || rd_resetn !== 1'b0) begin
      errors++; $display("FAIL p0_release: state=%b rstn=%b want 11 0", state_word[3:2], rd_resetn);
    end
    @(negedge clk); #1;
    checks++;
    if (state_word !== 32'd0) begin
      errors++; $display("FAIL p0_idle: got %h want 00000000", state_word);
    end
  endtask

  task automatic test_starvation();
    int exp_order[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int got, held, budget, port;
    logic [1:0] prev_grant;
    logic [3:0] prev_starve;
    do_reset();
    r_addr[0] = 32'hA0; r_addr[1] = 32'hB0; r_len[0] = 32'd4; r_len[1] = 32'd8;
    r_rstn[0] = 1'b1; r_rstn[1] = 1'b1;
    got = 0; held = 0; budget = 0;
    prev_grant = 2'b00; prev_starve = 4'd0;
    while (got < 10 && budget < 400) begin
      @(negedge clk); #1;
      budget++;
      r_rstn[0] = 1'b1; r_rstn[1] = 1'b1;
      if (state_word[5:4] != 2'b00 && prev_grant == 2'b00) begin
        port = state_word[5] ? 1 : 0;
        checks++;
        if (port !== exp_order[got]) begin
          errors++; $display("FAIL starve_order[%0d]: got port %0d want %0d", got, port, exp_order[got]);
        end
        if (port == 1) begin
          checks++;
          if (prev_starve !== 4'd4) begin
            errors++; $display("FAIL starve_cnt_before_g1[%0d]: got %0d want 4", got, prev_starve);
          end
        end
        got++;
        held = 0;
      end
      if (state_word[5:4] != 2'b00) begin
        held++;
        if (held >= 2) r_rstn[state_word[5] ? 1 : 0] = 1'b0;
      end
      prev_grant  = state_word[5:4];
      prev_starve = state_word[9:6];
    end
    checks++;
    if (got !== 10) begin
      errors++; $display("FAIL starve_timeout: saw %0d grants want 10", got);
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    r_next[0] = 1'b1; #1;
    checks++;
    if (rd_next !== 1'b0) begin
      errors++; $display("FAIL bp_idle: got %b want 0", rd_next);
    end
    r_rstn[1] = 1'b1; r_addr[1] = 32'h300; r_len[1] = 32'd16;
    @(negedge clk); #1;
    checks++;
    if (state_word[5:2] !== 4'b1010 || rd_address !== 32'h300) begin
      errors++; $display("FAIL bp_grant1: grant/state=%b addr=%h want 1010 300", state_word[5:2], rd_address);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      r_next[1] = 1'(i % 2); #1;
      checks++;
      if (rd_next !== r_next[1]) begin
        errors++; $display("FAIL bp_mirror[%0d]: got %b want %b", i, rd_next, r_next[1]);
      end
    end
  endtask

  task automatic test_error();
    do_reset();
    r_rstn[0] = 1'b1; r_addr[0] = 32'h40;
    @(negedge clk);
    rd_error = 1'b1; #1;
    checks++;
    if (r0_error !== 1'b1 || r1_error !== 1'b0) begin
      errors++; $display("FAIL err_route: r0=%b r1=%b want 1 0", r0_error, r1_error);
    end
    @(negedge clk);
    rd_error = 1'b0; #1;
    checks++;
    if (state_word[3:2] !== 2'b01 || r0_error !== 1'b0) begin
      errors++; $display("FAIL err_hold: state=%b err=%b want 01 0", state_word[3:2], r0_error);
    end
    r_rstn[0] = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (state_word[3:2] !== 2'b11) begin
      errors++; $display("FAIL err_release: state=%b want 11", state_word[3:2]);
    end
    @(negedge clk); #1;
    checks++;
    if (state_word[3:2] !== 2'b00) begin
      errors++; $display("FAIL err_idle: state=%b want 00", state_word[3:2]);
    end
  endtask

  task automatic test_addr_change();
    do_reset();
    r_rstn[0] = 1'b1; r_addr[0] = 32'h100; r_len[0] = 32'd5;
    @(negedge clk);
    r_addr[0] = 32'h200; r_len[0] = 32'd9;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (rd_address !== 32'h100 || rd_length !== 32'd5) begin
      errors++; $display("FAIL addr_hold: addr=%h len=%0d want 100 5", rd_address, rd_length);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    r_rstn[1] = 1'b1; r_addr[1] = 32'h55; r_len[1] = 32'd3;
    @(negedge clk);
    rd_valid = 1'b1; rd_data = $urandom; #1;
    checks++;
    if (r1_valid !== 1'b1 || r0_valid !== 1'b0) begin
      errors++; $display("FAIL rm_flow: r1_valid=%b r0_valid=%b want 1 0", r1_valid, r0_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (state_word !== 32'd0 || rd_resetn !== 1'b0 || rd_address !== 32'd0 || r1_valid !== 1'b0) begin
      errors++; $display("FAIL rm_reset: state=%h rstn=%b addr=%h r1_valid=%b want 0 0 0 0",
                         state_word, rd_resetn, rd_address, r1_valid);
    end
    rst = 1'b0; r_rstn[1] = 1'b0; rd_valid = 1'b0;
    r_rstn[0] = 1'b1; r_addr[0] = 32'h77; r_len[0] = 32'd1;
    @(negedge clk); #1;
    checks++;
    if (state_word[5:2] !== 4'b0101 || rd_resetn !== 1'b1 || rd_address !== 32'h77) begin
      errors++; $display("FAIL rm_regrant: grant/state=%b rstn=%b addr=%h want 0101 1 77",
                         state_word[5:2], rd_resetn, rd_address);
    end
  endtask

  task automatic test_random();
    logic [1:0] g;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 59) == 0);
      for (int p = 0; p < 2; p++) begin
        r_rstn[p] = ($urandom_range(0, 4) != 0);
        r_addr[p] = $urandom; r_len[p] = $urandom;
        r_next[p] = 1'($urandom);
      end
      rd_done = 1'($urandom); rd_error = 1'($urandom); rd_valid = 1'($urandom);
      rd_data = $urandom;
      #1;
      g = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
      checks++;
      if (state_word !== model_word()) begin
        errors++; $display("FAIL rnd_state[%0d]: got %h want %h", i, state_word, model_word());
      end
      checks++;
      if (rd_address !== m_addr || rd_length !== m_len || rd_resetn !== m_rstn) begin
        errors++; $display("FAIL rnd_reader[%0d]: got %h/%h/%b want %h/%h/%b", i,
                           rd_address, rd_length, rd_resetn, m_addr, m_len, m_rstn);
      end
      checks++;
      if ({r0_done, r0_error, r0_valid} !== ({3{g[0]}} & {rd_done, rd_error, rd_valid}) ||
          {r1_done, r1_error, r1_valid} !== ({3{g[1]}} & {rd_done, rd_error, rd_valid})) begin
        errors++; $display("FAIL rnd_gated[%0d]: r0=%b r1=%b owner=%0d", i,
                           {r0_done, r0_error, r0_valid}, {r1_done, r1_error, r1_valid}, m_owner);
      end
      checks++;
      if (rd_next !== ((g[0] & r_next[0]) | (g[1] & r_next[1])) || r0_data !== rd_data || r1_data !== rd_data) begin
        errors++; $display("FAIL rnd_next_data[%0d]: next=%b owner=%0d r0=%h r1=%h want data %h", i,
                           rd_next, m_owner, r0_data, r1_data, rd_data);
      end
    end
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      r_addr[p] = '0; r_len[p] = '0; r_rstn[p] = 1'b0; r_next[p] = 1'b0;
    end
    test_reset();
    test_port0_only();
    test_starvation();
    test_back_pressure();
    test_error();
    test_addr_change();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
